uart_tx_sched: RTL and testbench

Round-robin scheduler that shares a single `UART_tx` serializer between `NUM_REQ` byte producers. It also generates the serializer's one-cycle `baud_clk` strobe from a programmable divisor. It sits between the producers (command responder, debug printer, status streamer) and the `UART_tx` instance. It presents one frame at a time and reports per-frame completion back to the owning requester.

---
 rtl/uart_tx_sched.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter that shares one UART_tx serializer
// between NUM_REQ byte producers. It also generates the serializer's baud strobe.
// One frame is in flight at a time. Completion is reported back to the
// requester that owned the frame.
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [DIV_W-1:0]           baud_div,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       busy,
    output logic                       trmt,
    output logic [7:0]                 tx_data,
    output logic                       baud_clk,
    input  logic                       tx_done
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [ID_W:0]    NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);

    logic [1:0]         state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    cur_id_reg;
    logic [DIV_W-1:0]   div_q_reg;
    logic [DIV_W-1:0]   baud_cnt_reg;
    logic               tx_done_q_reg;
    logic [7:0]         tx_data_reg;
    logic               trmt_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic               done_reg;
    logic [ID_W-1:0]    done_id_reg;

    // Per-requester byte view of the flat data bus.
    logic [7:0] req_byte [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotate requests so that bit 0 is the requester at rr_ptr.
    // The lowest set bit of the rotated vector is then the winner.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      rot_off;
    logic [ID_W:0]        win_sum;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      next_ptr;
    logic [DIV_W-1:0]     div_sel;
    logic                 baud_hit;
    logic                 tx_done_rise;

    assign req_dbl = {req, req} >> rr_ptr_reg;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    // Priority pick of the first requesting slot after the pointer (lowest offset wins).
    always_comb begin
        rot_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rot_off = ID_W'(k);
            end
        end
    end

    assign win_sum  = {1'b0, rr_ptr_reg} + {1'b0, rot_off};
    assign winner   = (win_sum >= NUM_REQ_X) ? ID_W'(win_sum - NUM_REQ_X) : win_sum[ID_W-1:0];
    assign next_ptr = (cur_id_reg == LAST_ID) ? '0 : cur_id_reg + 1'b1;

    // Divisors below 2 cannot produce a distinct strobe period, so they are clamped.
    assign div_sel = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;

    assign baud_hit     = (state_reg == WAIT) && (baud_cnt_reg == div_q_reg - DIV_W'(1));
    assign tx_done_rise = tx_done & ~tx_done_q_reg;

    // Edge detector for tx_done. A level left over from the last frame never looks like a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done_q_reg <= 1'b0;
        end else begin
            tx_done_q_reg <= tx_done;
        end
    end

    // Scheduler FSM: arbitrate, issue one trmt/gnt pulse, then wait for frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            cur_id_reg  <= '0;
            div_q_reg   <= DIV_MIN;
            tx_data_reg <= 8'h00;
            trmt_reg    <= 1'b0;
            gnt_reg     <= '0;
            done_reg    <= 1'b0;
            done_id_reg <= '0;
        end else begin
            trmt_reg <= 1'b0;
            gnt_reg  <= '0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        tx_data_reg <= req_byte[winner];
                        cur_id_reg  <= winner;
                        div_q_reg   <= div_sel;
                        trmt_reg    <= 1'b1;
                        gnt_reg     <= NUM_REQ'(1) << winner;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rr_ptr_reg <= next_ptr;
                    state_reg  <= WAIT;
                end
                WAIT: begin
                    if (tx_done_rise) begin
                        done_reg    <= 1'b1;
                        done_id_reg <= cur_id_reg;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Baud counter: held at 0 until the frame starts, then wraps every div_q cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_reg <= '0;
        end else if (state_reg != WAIT) begin
            baud_cnt_reg <= '0;
        end else if (baud_hit) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + DIV_W'(1);
        end
    end

    assign gnt      = gnt_reg;
    assign trmt     = trmt_reg;
    assign tx_data  = tx_data_reg;
    assign done     = done_reg;
    assign done_id  = done_id_reg;
    assign busy     = (state_reg != IDLE);
    assign baud_clk = baud_hit;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched. A behavioural UART_tx stand-in serializes each frame.
// A scoreboard checks the grants, strobe timing, the frame bits and the completions.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [8*N-1:0] req_data;
    logic [DW-1:0] baud_div;
    logic [N-1:0]  gnt;
    logic          done;
    logic [1:0]    done_id;
    logic          busy;
    logic          trmt;
    logic [7:0]    tx_data;
    logic          baud_clk;
    logic          tx_done;

    uart_tx_sched #(.NUM_REQ(N), .DIV_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .baud_div (baud_div),
        .gnt      (gnt),
        .done     (done),
        .done_id  (done_id),
        .busy     (busy),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .baud_clk (baud_clk),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // ---------------- behavioural UART_tx stand-in ----------------
    int         stale_dly = 0;
    int         clr_cnt;
    int         ser_cnt;
    logic [9:0] ser_shreg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_shreg <= 10'h3FF;
            ser_cnt   <= 10;
            clr_cnt   <= 0;
            tx_done   <= 1'b0;
        end else if (trmt) begin
            ser_shreg <= {1'b1, tx_data, 1'b0};
            ser_cnt   <= 0;
            if (stale_dly == 0) tx_done <= 1'b0;
            else                clr_cnt <= stale_dly;
        end else begin
            if (clr_cnt != 0) begin
                clr_cnt <= clr_cnt - 1;
                if (clr_cnt == 1) tx_done <= 1'b0;
            end
            if (baud_clk && ser_cnt < 10) begin
                ser_shreg <= {1'b1, ser_shreg[9:1]};
                ser_cnt   <= ser_cnt + 1;
                if (ser_cnt == 9) tx_done <= 1'b1;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int         id;
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t gnt_q[$];
    int   mdl_ptr = 0;

    // Round robin from the rules: first requester at or after the pointer, with wrap.
    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mdl_ptr + k) % N;
            if (mask[i]) begin
                mdl_ptr = (i + 1) % N;
                return i;
            end
        end
        return 0;
    endfunction

    function automatic exp_t make_exp(input int w, input logic [8*N-1:0] data, input int div);
        exp_t e;
        e.id   = w;
        e.data = data[8*w +: 8];
        e.div  = (div < 2) ? 2 : div;
        return e;
    endfunction

    exp_t       cur;
    bit         frame_open = 0;
    int         issue_cyc = 0;
    int         strobe_n = 0;
    int         rise_cyc = -10;
    logic       prev_txd = 1'b0;
    logic [9:0] bits;

    // Monitor: pops expectations when the DUT grants, then follows the frame through to done.
    always @(negedge clk) begin
        if (rst) begin
            gnt_q.delete();
            frame_open = 0;
            strobe_n   = 0;
            prev_txd   = 1'b0;
            rise_cyc   = -10;
        end else begin
            logic [N-1:0] exp_g;
            if (tx_done && !prev_txd) rise_cyc = cyc;
            prev_txd = tx_done;
            if (gnt != '0 || trmt) begin
                if (gnt_q.size() == 0) begin
                    fail("unexpected_grant");
                end else begin
                    cur = gnt_q.pop_front();
                    exp_g = '0;
                    exp_g[cur.id] = 1'b1;
                    chk("grant_id", gnt, exp_g);
                    chk("trmt_with_gnt", trmt, 1);
                    chk("tx_data", tx_data, cur.data);
                    chk("grant_while_frame_open", frame_open, 0);
                    frame_open = 1;
                    issue_cyc  = cyc;
                    strobe_n   = 0;
                end
            end
            if (baud_clk) begin
                if (!frame_open || strobe_n >= 10) begin
                    fail("stray_baud_clk");
                end else begin
                    chk("baud_strobe_time", cyc - issue_cyc, cur.div * (strobe_n + 1));
                    bits[strobe_n] = ser_shreg[0];
                    strobe_n++;
                    if (strobe_n == 10) chk("frame_bits", bits, {1'b1, cur.data, 1'b0});
                end
            end
            if (frame_open && cyc == rise_cyc + 1) chk("done_on_rise", done, 1);
            if (done) begin
                if (!frame_open) begin
                    fail("done_without_frame");
                end else begin
                    chk("done_id", done_id, cur.id);
                    chk("done_latency", cyc - rise_cyc, 1);
                    $display("frame id=%0d data=%02h div=%0d", cur.id, cur.data, cur.div);
                end
                frame_open = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_id"}, done_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_trmt"}, trmt, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_baud_clk"}, baud_clk, 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) fail("idle_timeout");
    endtask

    task automatic issue(input logic [N-1:0] mask, input logic [8*N-1:0] data,
                         input int div, input int mid_div, input int dly, input bit wait_done);
        int w;
        logic [N-1:0] exp_g;
        wait_idle();
        stale_dly = dly;
        req_data  = data;
        baud_div  = DW'(div);
        w = rr_pick(mask);
        gnt_q.push_back(make_exp(w, data, div));
        req = mask;
        @(negedge clk);
        exp_g = '0;
        exp_g[w] = 1'b1;
        chk("gnt_latency", gnt, exp_g);
        chk("busy_after_grant", busy, 1);
        req      = '0;
        baud_div = DW'(mid_div);
        if (wait_done) wait_idle();
    endtask

    task automatic hold(input logic [N-1:0] mask, input logic [8*N-1:0] data,
                        input int div, input int count);
        int got;
        int t;
        wait_idle();
        stale_dly = 2;
        req_data  = data;
        baud_div  = DW'(div);
        for (int i = 0; i < count; i++) gnt_q.push_back(make_exp(rr_pick(mask), data, div));
        req = mask;
        got = 0;
        t = 0;
        while (got < count && t < 20000) begin
            @(negedge clk);
            t++;
            if (gnt != '0) got++;
        end
        req = '0;
        chk("held_grant_count", got, count);
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int t;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        baud_div = DW'(16);
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // All four held: 0,1,2,3,0,1,2,3; then 1001 from pointer 0: 0 then 3.
        hold(4'b1111, 32'h44332211, 3, 8);
        hold(4'b1001, 32'h44332211, 3, 2);

        // Single request from requester 2 with 0xA5 at 16 cycles/bit.
        issue(4'b0100, 32'h00A50000, 16, 16, 2, 1);

        // Mid-frame divisor change, next frame at 4, then divisor 0 acting as 2.
        issue(4'b0001, 32'h0000003C, 16, 4, 0, 1);
        issue(4'b0010, 32'h0000C300, 4, 4, 3, 1);
        issue(4'b1000, 32'h81000000, 0, 0, 4, 1);

        // Randomized masks, data, divisors and stale tx_done durations.
        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, 15));
            issue(m, $urandom(), $urandom_range(0, 6), $urandom_range(0, 20),
                  $urandom_range(0, 4), 1);
        end

        // Asynchronous reset during bit 4 of a frame.
        issue(4'b0010, 32'h00005A00, 8, 8, 1, 0);
        t = 0;
        while (strobe_n < 4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail("reset_test_timeout");
        #2 rst = 1'b1;
        #1 check_reset("midframe_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mdl_ptr = 0;
        check_reset("after_release");
        issue(4'b1111, 32'hDDCCBBAA, 5, 5, 1, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", gnt_q.size(), 0);
        chk("no_frame_open", frame_open, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
